// File: rtl/exu_cal_arb.sv
// Round-robin arbiter that lets three requesters (ALU, BJU, LSU-AGU) share one
// calculation centre, keeping a single transaction in flight at any time.
//
// state | meaning
// IDLE  | no transaction; a waiting request is granted in this cycle
// ISSUE | latched bundle offered to the calc centre until it is accepted
// WAIT  | bundle accepted, waiting for the result
// DONE  | result returned to the owning requester for one cycle
module exu_cal_arb #(
  parameter int OPB_W = 73,
  parameter int NREQ  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   hs_rq4arb_val,
  output logic [NREQ-1:0]   hs_arb4rq_rdy,
  input  logic [OPB_W-1:0]  i_rq0_opb,
  input  logic [OPB_W-1:0]  i_rq1_opb,
  input  logic [OPB_W-1:0]  i_rq2_opb,
  output logic [NREQ-1:0]   o_res_val,
  output logic [31:0]       o_res,
  output logic              hs_arb4cal_val,
  input  logic              hs_cal4arb_rdy,
  output logic [OPB_W-1:0]  o_cal_opb,
  input  logic              i_cal_res_val,
  input  logic [31:0]       i_cal_res,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        id_q;
  logic [OPB_W-1:0]  opb_q;
  logic [31:0]       res_q;

  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        win_id;
  logic              win_val;
  logic [OPB_W-1:0]  win_opb;
  logic              res_take;

  function automatic logic [1:0] nxt_idx(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order ptr, ptr+1, ptr+2 (mod 3); earlier candidates win.
  always_comb begin
    cand0   = ptr;
    cand1   = nxt_idx(cand0);
    cand2   = nxt_idx(cand1);
    win_val = |hs_rq4arb_val;
    if (hs_rq4arb_val[cand0])      win_id = cand0;
    else if (hs_rq4arb_val[cand1]) win_id = cand1;
    else                           win_id = cand2;
    case (win_id)
      2'd0:    win_opb = i_rq0_opb;
      2'd1:    win_opb = i_rq1_opb;
      default: win_opb = i_rq2_opb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_take  = 1'b0;
    case (state)
      IDLE:  if (win_val) state_nxt = ISSUE;
      ISSUE: if (hs_cal4arb_rdy) begin
               res_take  = i_cal_res_val;
               state_nxt = i_cal_res_val ? DONE : WAIT;
             end
      WAIT:  if (i_cal_res_val) begin
               res_take  = 1'b1;
               state_nxt = DONE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= 2'd0;
      id_q  <= 2'd0;
      opb_q <= '0;
      res_q <= '0;
    end else begin
      if (state == IDLE && win_val) begin
        id_q  <= win_id;
        opb_q <= win_opb;
      end
      if (res_take) res_q <= i_cal_res;
      if (state == DONE) ptr <= nxt_idx(id_q);
    end
  end

  // Outputs are forced low while rst is asserted, even before state settles.
  always_comb begin
    hs_arb4rq_rdy  = '0;
    o_res_val      = '0;
    o_res          = '0;
    hs_arb4cal_val = 1'b0;
    o_cal_opb      = '0;
    o_busy         = 1'b0;
    if (!rst) begin
      o_busy = (state != IDLE);
      case (state)
        IDLE:  if (win_val) hs_arb4rq_rdy = NREQ'(3'b001 << win_id);
        ISSUE: begin
                 hs_arb4cal_val = 1'b1;
                 o_cal_opb      = opb_q;
               end
        DONE:  begin
                 o_res_val = NREQ'(3'b001 << id_q);
                 o_res     = res_q;
               end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_cal_arb.sv
// Directed self-checking bench for exu_cal_arb; inputs change 1 ns after the
// rising edge and outputs are compared 3 ns after it.
module tb_exu_cal_arb;

  localparam int OPB_W = 73;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        hs_rq4arb_val;
  logic [2:0]        hs_arb4rq_rdy;
  logic [OPB_W-1:0]  i_rq0_opb, i_rq1_opb, i_rq2_opb;
  logic [2:0]        o_res_val;
  logic [31:0]       o_res;
  logic              hs_arb4cal_val;
  logic              hs_cal4arb_rdy;
  logic [OPB_W-1:0]  o_cal_opb;
  logic              i_cal_res_val;
  logic [31:0]       i_cal_res;
  logic              o_busy;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [OPB_W-1:0] B0 = 73'h0A5_1234_5678_9ABC_DEF0;
  localparam logic [OPB_W-1:0] B1 = 73'h13C_0F0F_0F0F_1111_2222;
  localparam logic [OPB_W-1:0] B2 = 73'h1FF_8000_0001_7FFF_FFFE;
  localparam logic [OPB_W-1:0] BX = 73'h155_DEAD_DEAD_DEAD_DEAD;

  exu_cal_arb #(.OPB_W(OPB_W), .NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .hs_rq4arb_val(hs_rq4arb_val), .hs_arb4rq_rdy(hs_arb4rq_rdy),
    .i_rq0_opb(i_rq0_opb), .i_rq1_opb(i_rq1_opb), .i_rq2_opb(i_rq2_opb),
    .o_res_val(o_res_val), .o_res(o_res),
    .hs_arb4cal_val(hs_arb4cal_val), .hs_cal4arb_rdy(hs_cal4arb_rdy),
    .o_cal_opb(o_cal_opb),
    .i_cal_res_val(i_cal_res_val), .i_cal_res(i_cal_res),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OPB_W-1:0] got,
                     input logic [OPB_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rdy"},     hs_arb4rq_rdy, 0);
    chk({tag, ".resval"},  o_res_val, 0);
    chk({tag, ".res"},     o_res, 0);
    chk({tag, ".calval"},  hs_arb4cal_val, 0);
    chk({tag, ".calopb"},  o_cal_opb, 0);
  endtask

  int order [4] = '{0, 1, 2, 0};
  logic [OPB_W-1:0] bun [3];

  initial begin
    bun[0] = B0; bun[1] = B1; bun[2] = B2;
    rst = 1'b1; hs_rq4arb_val = 3'b111;
    i_rq0_opb = B0; i_rq1_opb = B1; i_rq2_opb = B2;
    hs_cal4arb_rdy = 1'b0; i_cal_res_val = 1'b0; i_cal_res = '0;

    // reset with requests pending: everything must stay low
    step(); step(); settle();
    chk_quiet("rst");
    chk("rst.busy", o_busy, 0);
    step();

    // single request, result in the issue cycle
    rst = 1'b0; hs_rq4arb_val = 3'b001; settle();
    chk("a0.rdy", hs_arb4rq_rdy, 3'b001);
    chk("a0.busy", o_busy, 0);
    chk("a0.calval", hs_arb4cal_val, 0);
    step();
    hs_rq4arb_val = 3'b000; i_rq0_opb = BX;
    hs_cal4arb_rdy = 1'b1; i_cal_res_val = 1'b1; i_cal_res = 32'h0000_0042; settle();
    chk("a1.calval", hs_arb4cal_val, 1);
    chk("a1.opb", o_cal_opb, B0);
    chk("a1.rdy", hs_arb4rq_rdy, 0);
    chk("a1.busy", o_busy, 1);
    chk("a1.resval", o_res_val, 0);
    step();
    // stray result pulse while in DONE
    hs_cal4arb_rdy = 1'b0; i_cal_res = 32'h0000_0099; settle();
    chk("a2.resval", o_res_val, 3'b001);
    chk("a2.res", o_res, 32'h42);
    chk("a2.calval", hs_arb4cal_val, 0);
    chk("a2.opb", o_cal_opb, 0);
    step();
    // stray result pulse while in IDLE
    settle();
    chk("a3.busy", o_busy, 0);
    chk_quiet("a3");
    step();
    i_cal_res_val = 1'b0; settle();
    chk("a4.busy", o_busy, 0);
    chk("a4.resval", o_res_val, 0);

    // fairness: all requesters active, calc centre always ready with result
    rst = 1'b1; i_rq0_opb = B0; step();
    rst = 1'b0; hs_rq4arb_val = 3'b111;
    hs_cal4arb_rdy = 1'b1; i_cal_res_val = 1'b1;
    for (int c = 0; c < 12; c++) begin
      i_cal_res = 32'h100 + c; settle();
      if (c % 3 == 0) chk($sformatf("f%0d.rdy", c), hs_arb4rq_rdy, 3'b001 << order[c/3]);
      else            chk($sformatf("f%0d.rdy", c), hs_arb4rq_rdy, 0);
      if (c % 3 == 1) chk($sformatf("f%0d.opb", c), o_cal_opb, bun[order[c/3]]);
      if (c % 3 == 2) begin
        chk($sformatf("f%0d.resval", c), o_res_val, 3'b001 << order[c/3]);
        chk($sformatf("f%0d.res", c), o_res, 32'h100 + c - 1);
      end
      step();
    end
    // ptr is now 1

    // back-pressure on rq1
    hs_rq4arb_val = 3'b010; hs_cal4arb_rdy = 1'b0; i_cal_res_val = 1'b0; settle();
    chk("c0.rdy", hs_arb4rq_rdy, 3'b010);
    step();
    hs_rq4arb_val = 3'b000; i_rq1_opb = BX; i_cal_res_val = 1'b1; i_cal_res = 32'hBAD0_BAD0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("c%0d.calval", c), hs_arb4cal_val, 1);
      chk($sformatf("c%0d.opb", c), o_cal_opb, B1);
      step();
    end
    hs_cal4arb_rdy = 1'b1; i_cal_res_val = 1'b0; settle();
    chk("c5.calval", hs_arb4cal_val, 1);
    step();
    hs_cal4arb_rdy = 1'b0; settle();
    chk("c6.calval", hs_arb4cal_val, 0);
    chk("c6.busy", o_busy, 1);
    step();
    i_cal_res_val = 1'b1; i_cal_res = 32'h1234_5678; settle();
    chk("c7.resval", o_res_val, 0);
    step();
    i_cal_res_val = 1'b0; settle();
    chk("c8.resval", o_res_val, 3'b010);
    chk("c8.res", o_res, 32'h1234_5678);
    step();
    i_rq1_opb = B1;
    // ptr is now 2

    // reset while waiting for a result
    hs_rq4arb_val = 3'b100; settle();
    chk("e0.rdy", hs_arb4rq_rdy, 3'b100);
    step();
    hs_rq4arb_val = 3'b000; hs_cal4arb_rdy = 1'b1; step();
    hs_cal4arb_rdy = 1'b0; settle();
    chk("e2.busy", o_busy, 1);
    rst = 1'b1; #1;
    chk_quiet("e2rst");
    chk("e2rst.busy", o_busy, 0);
    step();
    rst = 1'b0; i_cal_res_val = 1'b1; i_cal_res = 32'h5555_AAAA; settle();
    chk("e3.busy", o_busy, 0);
    chk_quiet("e3");
    step();
    i_cal_res_val = 1'b0; settle();
    chk("e4.resval", o_res_val, 0);
    hs_rq4arb_val = 3'b111; #1;
    chk("e4.ptr0", hs_arb4rq_rdy, 3'b001);
    step();
    hs_rq4arb_val = 3'b000; hs_cal4arb_rdy = 1'b1; i_cal_res_val = 1'b1; i_cal_res = 32'h77; step();
    hs_cal4arb_rdy = 1'b0; i_cal_res_val = 1'b0; settle();
    chk("e6.resval", o_res_val, 3'b001);
    step();
    hs_rq4arb_val = 3'b100; settle();
    chk("e7.rdy", hs_arb4rq_rdy, 3'b100);
    step();
    hs_rq4arb_val = 3'b000; hs_cal4arb_rdy = 1'b1; i_cal_res_val = 1'b1; i_cal_res = 32'h88; settle();
    chk("e8.opb", o_cal_opb, B2);
    step();
    hs_cal4arb_rdy = 1'b0; i_cal_res_val = 1'b0; settle();
    chk("e9.resval", o_res_val, 3'b100);
    chk("e9.res", o_res, 32'h88);
    step();

    // slow result on rq2
    hs_rq4arb_val = 3'b100; settle();
    chk("d0.rdy", hs_arb4rq_rdy, 3'b100);
    step();
    hs_rq4arb_val = 3'b000; hs_cal4arb_rdy = 1'b1; step();
    hs_cal4arb_rdy = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      settle();
      chk($sformatf("d%0d.busy", c), o_busy, 1);
      chk($sformatf("d%0d.resval", c), o_res_val, 0);
      chk($sformatf("d%0d.calval", c), hs_arb4cal_val, 0);
      step();
    end
    i_cal_res_val = 1'b1; i_cal_res = 32'hDEAD_BEEF; settle();
    chk("d5.resval", o_res_val, 0);
    step();
    i_cal_res_val = 1'b0; i_cal_res = 32'h0; settle();
    chk("d6.resval", o_res_val, 3'b100);
    chk("d6.res", o_res, 32'hDEAD_BEEF);
    step(); settle();
    chk("d7.busy", o_busy, 0);
    chk("d7.resval", o_res_val, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
